// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : instruction-fetch stage feeding the IF/ID pipeline register.
//               Owns the fetch PC, keeps one request outstanding to imem and
//               handles hazard stalls and EX redirects.
// Revision    : 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        valid_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      state_q,       state_d;
  logic [31:0] fetch_pc_q,    fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] hold_pc_q,     hold_pc_d;
  logic [31:0] hold_inst_q,   hold_inst_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= 32'h0;
      hold_pc_q     <= 32'h0;
      hold_inst_q   <= NOP_INST;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      hold_pc_q     <= hold_pc_d;
      hold_inst_q   <= hold_inst_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    inflight_pc_d  = inflight_pc_q;
    hold_pc_d      = hold_pc_q;
    hold_inst_d    = hold_inst_q;
    imem_req_valid = 1'b0;
    imem_req_addr  = fetch_pc_q;
    valid_out      = 1'b0;
    pc_out         = 32'h0;
    inst_out       = NOP_INST;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      // Prefetch: request goes out even while IF/ID is stalled.
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + 32'd4;
          state_d       = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid) begin
          valid_out = 1'b1;
          pc_out    = inflight_pc_q;
          inst_out  = imem_rsp_data;
          if (stall) begin
            hold_pc_d   = inflight_pc_q;
            hold_inst_d = imem_rsp_data;
            state_d     = S_HOLD;
          end else begin
            // Back-to-back issue keeps one instruction per cycle.
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
              inflight_pc_d = fetch_pc_q;
              fetch_pc_d    = fetch_pc_q + 32'd4;
              state_d       = S_WAIT;
            end else begin
              state_d = S_REQ;
            end
          end
        end
      end

      S_HOLD: begin
        valid_out = 1'b1;
        pc_out    = hold_pc_q;
        inst_out  = hold_inst_q;
        if (!stall) begin
          state_d = S_REQ;
        end
      end

      S_DROP: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect overrides everything above, including a same-cycle response.
    if (redirect) begin
      fetch_pc_d     = redirect_pc;
      inflight_pc_d  = inflight_pc_q;
      hold_pc_d      = 32'h0;
      hold_inst_d    = NOP_INST;
      imem_req_valid = 1'b0;
      valid_out      = 1'b0;
      pc_out         = 32'h0;
      inst_out       = NOP_INST;
      case (state_q)
        // Leave DROP once the stale response has arrived, or it would wait forever.
        S_WAIT, S_DROP: state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : randomized scoreboard bench for fetch_stage with a
//                  behavioural instruction-memory and fetch-stream model.
// Revision       : 1.0
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          NCYC = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .valid_out      (valid_out)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t       exp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          last_prog = 0;

  // memory model state
  bit          pend = 1'b0;
  bit          pend_stale = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          rsp_now = 1'b0;
  logic [31:0] exp_fetch = 32'h0;
  bit          prev_stuck = 1'b0;
  bit          prev_redir = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          p_stall = 0;
  int          p_nrdy = 0;
  int          p_redir = 0;
  int          lat_max = 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares presented instructions against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk1("valid_out", valid_out, exp_q.size() != 0);
        if (valid_out) begin
          last_prog = cyc;
          if (exp_q.size() != 0) begin
            chk("pc_out", pc_out, exp_q[0].pc);
            chk("inst_out", inst_out, exp_q[0].inst);
            if (!stall) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_pc_out", pc_out, 32'h0);
          chk("idle_inst_out", inst_out, NOP);
        end
      end
    end
  end

  // Driver: stimulus plus instruction-memory model.
  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk1("rst_valid_out", valid_out, 1'b0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_inst_out", inst_out, NOP);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int c = 1; c <= NCYC; c++) begin
      cyc = c;
      if (c == 9 || c % 250 == 0) begin
        p_stall = int'($urandom_range(60));
        p_nrdy  = int'($urandom_range(60));
        p_redir = int'($urandom_range(12));
        lat_max = int'($urandom_range(4, 1));
      end

      rsp_now = 1'b0;
      if (pend) begin
        pend_cnt--;
        rsp_now = (pend_cnt == 0);
      end
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = rsp_now ? memf(pend_addr) : $urandom;

      if (c <= 8) begin
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        redirect       = 1'b0;
      end else begin
        stall          = ($urandom_range(99) < p_stall);
        imem_req_ready = ($urandom_range(99) >= p_nrdy);
        redirect       = !prev_redir && ($urandom_range(99) < p_redir);
        case ($urandom_range(3))
          0:       redirect_pc = 32'h0000_0100;
          1:       redirect_pc = 32'h0000_0200;
          2:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4);
          default: redirect_pc = $urandom;
        endcase
      end
      if (c == 300 || c == 1100) begin
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
      end

      // Redirect squashes everything not yet consumed, including this cycle's response.
      if (redirect) begin
        exp_fetch = redirect_pc;
        exp_q.delete();
        if (pend) pend_stale = 1'b1;
      end else if (rsp_now && !pend_stale) begin
        exp_q.push_back({pend_addr, memf(pend_addr)});
      end

      #3;
      if (c == 1) chk1("first_cycle_no_req", imem_req_valid, 1'b0);
      if (c >= 2 && c <= 8) begin
        chk1("steady_req_valid", imem_req_valid, 1'b1);
        chk("steady_req_addr", imem_req_addr, 32'((c - 2) * 4));
      end
      if (c >= 3 && c <= 8) begin
        chk1("steady_valid_out", valid_out, 1'b1);
        chk("steady_pc_out", pc_out, 32'((c - 3) * 4));
      end
      if (prev_stuck && !redirect) begin
        chk1("req_held", imem_req_valid, 1'b1);
        chk("req_addr_stable", imem_req_addr, prev_addr);
      end
      if (valid_out && stall) chk1("no_req_while_stalled", imem_req_valid, 1'b0);
      if (redirect) chk1("no_req_on_redirect", imem_req_valid, 1'b0);
      if (pend && !rsp_now) chk1("single_outstanding", imem_req_valid, 1'b0);

      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_fetch);
        exp_fetch  = exp_fetch + 32'd4;
        pend       = 1'b1;
        pend_stale = 1'b0;
        pend_cnt   = (c <= 8) ? 1 : int'($urandom_range(lat_max, 1));
        pend_addr  = imem_req_addr;
        last_prog  = c;
      end else if (rsp_now) begin
        pend = 1'b0;
      end

      if (c - last_prog > 150) begin
        checks++;
        failures++;
        $display("FAIL progress_timeout no accept or presentation for %0d cycles", c - last_prog);
        last_prog = c;
      end

      prev_stuck = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
      prev_redir = redirect;
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-cycle must take effect before the next edge.
    mon_en         = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    stall          = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_req_valid", imem_req_valid, 1'b0);
    chk("async_rst_req_addr", imem_req_addr, 32'h0);
    chk1("async_rst_valid_out", valid_out, 1'b0);
    chk("async_rst_inst_out", inst_out, NOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
